// File: rtl/cochlea_readout_capture.sv
// Captures 2-bit I/Q readout nibbles from one selected channel, packs 8 into a 32-bit word,
// and buffers the words in a FIFO that a Wishbone classic slave drains.
module cochlea_readout_capture #(
   parameter int          N_CH       = 6,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic [N_CH-1:0]   ch_clk,
   input  logic [2*N_CH-1:0] read_out_I,
   input  logic [2*N_CH-1:0] read_out_Q,
   output logic              irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic          en;
   logic [2:0]    ch_sel;
   logic          ack_q;
   logic          irq_q;

   logic          sel_clk;
   logic [3:0]    sel_dat;
   logic          clk_s1, clk_s2, clk_d;
   logic [3:0]    dat_s1, dat_s2;
   logic          fall;

   logic [2:0]    cnt;
   logic [31:0]   word;
   logic [31:0]   push_word;
   logic          push_v;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          overflow;
   logic          full, empty;
   logic          do_push;

   logic          adr_hit, acc;
   logic [1:0]    reg_idx;
   logic          ctrl_wr, flush_now, sel_change, stat_clr, pop;
   logic [31:0]   rd_data;
   logic          unused_ok;

   assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:9], wbs_dat_i[7:5]};

   // Wishbone decode; register side effects land on the edge that closes the ack cycle
   assign adr_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign acc        = ack_q & adr_hit;
   assign reg_idx    = wbs_adr_i[3:2];
   assign ctrl_wr    = acc & wbs_we_i & (reg_idx == 2'd0) & wbs_sel_i[0];
   assign flush_now  = ctrl_wr & wbs_dat_i[4];
   assign sel_change = ctrl_wr & (wbs_dat_i[3:1] != ch_sel);
   assign stat_clr   = acc & wbs_we_i & (reg_idx == 2'd1) & wbs_sel_i[1] & wbs_dat_i[8];
   assign pop        = acc & ~wbs_we_i & (reg_idx == 2'd2) & ~empty;

   assign full    = (level == LW'(FIFO_DEPTH));
   assign empty   = (level == '0);
   assign do_push = push_v & (~full | pop);

   // Out-of-range ch_sel matches no channel, so the strobe stays low and nothing captures
   always_comb begin
      sel_clk = 1'b0;
      sel_dat = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (ch_sel == c[2:0]) begin
            sel_clk = ch_clk[c];
            sel_dat = {read_out_Q[2*c +: 2], read_out_I[2*c +: 2]};
         end
      end
   end

   assign fall = en & clk_d & ~clk_s2;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q  <= 1'b0;
         en     <= 1'b0;
         ch_sel <= '0;
         irq_q  <= 1'b0;
         clk_s1 <= 1'b0;
         clk_s2 <= 1'b0;
         clk_d  <= 1'b0;
         dat_s1 <= '0;
         dat_s2 <= '0;
      end else begin
         ack_q  <= adr_hit & ~ack_q;
         if (ctrl_wr) begin
            en     <= wbs_dat_i[0];
            ch_sel <= wbs_dat_i[3:1];
         end
         irq_q  <= en & ~empty;
         clk_s1 <= sel_clk;
         clk_s2 <= clk_s1;
         clk_d  <= clk_s2;
         dat_s1 <= sel_dat;
         dat_s2 <= dat_s1;
      end
   end

   // Packer: completed word is staged one cycle, then written to the FIFO
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cnt       <= '0;
         word      <= '0;
         push_word <= '0;
         push_v    <= 1'b0;
      end else begin
         push_v <= 1'b0;
         if (flush_now || sel_change || !en) begin
            cnt  <= '0;
            word <= '0;
         end else if (fall) begin
            word[{cnt, 2'b00} +: 4] <= dat_s2;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
               push_word <= {dat_s2, word[27:0]};
               push_v    <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && !flush_now && do_push)
         mem[wr_ptr] <= push_word;
   end

   // On a full push+pop the write reuses the slot being popped, becoming the new tail
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || flush_now) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(do_push) - LW'(pop);
         if (push_v && full && !pop)
            overflow <= 1'b1;
         else if (stat_clr)
            overflow <= 1'b0;
      end
   end

   always_comb begin
      rd_data = '0;
      case (reg_idx)
         2'd0: rd_data = {27'b0, 1'b0, ch_sel, en};
         2'd1: begin
            rd_data[LW-1:0] = level;
            rd_data[8]      = overflow;
            rd_data[9]      = empty;
            rd_data[10]     = full;
         end
         2'd2: rd_data = empty ? 32'h0 : mem[rd_ptr];
         default: rd_data = '0;
      endcase
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = ack_q ? rd_data : 32'h0;
   assign irq       = irq_q;

endmodule
